// File: rtl/keypad_pkg.sv
// Shared keypad constants, scan state type and small key-vector helpers.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic {
        DRIVE  = 1'b0,
        SAMPLE = 1'b1
    } scan_state_t;

    // Key indices (bit = row*NUM_COLS + col) as wired to the tone generators
    localparam int unsigned KEY_C4 = 0;
    localparam int unsigned KEY_D4 = 1;
    localparam int unsigned KEY_E4 = 2;
    localparam int unsigned KEY_F4 = 3;
    localparam int unsigned KEY_G4 = 4;
    localparam int unsigned KEY_A4 = 5;
    localparam int unsigned KEY_B4 = 6;
    localparam int unsigned KEY_C5 = 7;
    localparam int unsigned KEY_D5 = 8;
    localparam int unsigned KEY_E5 = 9;
    localparam int unsigned KEY_F5 = 10;
    localparam int unsigned KEY_G5 = 11;

    // Frame bits belonging to column 0; shift left by the column index for others
    localparam logic [NUM_KEYS-1:0] COL0_MASK = 12'h249;

    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    // Place row samples onto the column-0 frame bit positions
    function automatic logic [NUM_KEYS-1:0] spread_rows(input logic [NUM_ROWS-1:0] rows);
        return {2'b00, rows[3], 2'b00, rows[2], 2'b00, rows[1], 2'b00, rows[0]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: counts identical consecutive frames, rejects multi-key
// frames and emits one-cycle press/release pulses when the output changes.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] frame,
    input  logic                frame_valid,
    output logic [NUM_KEYS-1:0] keypad_out,
    output logic                key_press,
    output logic                key_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] prev_frame;
    logic [NUM_KEYS-1:0] prev_frame_nxt;
    logic [NUM_KEYS-1:0] keypad_nxt;
    logic [NUM_KEYS-1:0] new_key;
    logic [CNT_W-1:0]    stable_cnt;
    logic [CNT_W-1:0]    stable_nxt;
    logic                press_nxt;
    logic                release_nxt;

    // The frame being completed counts toward the stable total
    always_comb begin
        prev_frame_nxt = prev_frame;
        stable_nxt     = stable_cnt;
        keypad_nxt     = keypad_out;
        new_key        = '0;
        press_nxt      = 1'b0;
        release_nxt    = 1'b0;
        if (frame_valid) begin
            if (frame == prev_frame) begin
                stable_nxt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
            end else begin
                stable_nxt = CNT_W'(1);
            end
            prev_frame_nxt = frame;
            if (stable_nxt == CNT_MAX) begin
                new_key     = is_one_hot(frame) ? frame : '0;
                keypad_nxt  = new_key;
                press_nxt   = (new_key != '0) && (new_key != keypad_out);
                release_nxt = (new_key == '0) && (keypad_out != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_frame  <= '0;
            stable_cnt  <= '0;
            keypad_out  <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            prev_frame  <= prev_frame_nxt;
            stable_cnt  <= stable_nxt;
            keypad_out  <= keypad_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x3 keypad scanner: row synchronizer, column-drive scan FSM and frame
// assembly feeding the debounce stage.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [NUM_KEYS-1:0] keypad_out,
    output logic                key_press,
    output logic                key_release
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = $clog2(NUM_COLS);

    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;
    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [COL_W-1:0]    col_idx;
    logic [COL_W-1:0]    col_nxt;
    logic [NUM_COLS-1:0] col_out_nxt;
    logic [NUM_KEYS-1:0] frame;
    logic [NUM_KEYS-1:0] frame_nxt;
    logic [NUM_KEYS-1:0] frame_c;
    logic                frame_valid_c;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // DRIVE spends SCAN_DIV-1 cycles, SAMPLE one, so each column gets SCAN_DIV cycles
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        col_nxt       = col_idx;
        col_out_nxt   = col_out;
        frame_nxt     = frame;
        frame_valid_c = 1'b0;
        frame_c       = (frame & ~(COL0_MASK << col_idx)) | (spread_rows(row_sync) << col_idx);
        case (state)
            DRIVE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SCAN_DIV - 2)) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                frame_nxt     = frame_c;
                frame_valid_c = (col_idx == COL_W'(NUM_COLS - 1));
                cnt_nxt       = '0;
                col_nxt       = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + COL_W'(1);
                col_out_nxt   = NUM_COLS'(1) << col_nxt;
                state_nxt     = DRIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DRIVE;
            cnt     <= '0;
            col_idx <= '0;
            col_out <= NUM_COLS'(1);
            frame   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            col_idx <= col_nxt;
            col_out <= col_out_nxt;
            frame   <= frame_nxt;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame_c),
        .frame_valid(frame_valid_c),
        .keypad_out (keypad_out),
        .key_press  (key_press),
        .key_release(key_release)
    );

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Scoreboard bench for keypad_matrix_scan: a keypad model drives rows from
// col_out; expected output events are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_keypad_matrix_scan;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int FRAME   = 3 * SCAN_DIV;
    localparam int LAT_MAX = (DEB + 1) * FRAME + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [11:0] keypad_out;
    logic        key_press;
    logic        key_release;

    logic [2:0]  held_row [4];

    typedef struct {
        logic [11:0] value;
        logic        press;
        logic        rel;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc;

    always #5 clk = ~clk;

    // Pressed key at (r,c) connects column c drive to row r
    assign row_in = {|(held_row[3] & col_out), |(held_row[2] & col_out),
                     |(held_row[1] & col_out), |(held_row[0] & col_out)};

    keypad_matrix_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .keypad_out (keypad_out),
        .key_press  (key_press),
        .key_release(key_release)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_keys(input logic [11:0] k);
        held_row[0] = k[2:0];
        held_row[1] = k[5:3];
        held_row[2] = k[8:6];
        held_row[3] = k[11:9];
    endtask

    task automatic expect_ev(input logic [11:0] v, input logic p, input logic r);
        ev_t e;
        e.value = v;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for keypad_out to reach a value, then confirm the scoreboard drained
    task automatic wait_out(input string name, input logic [11:0] v, input int budget,
                            output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (keypad_out !== v && cycles < budget);
        check({name, "_reached"}, 32'(keypad_out), 32'(v));
        #1;
        check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every output change or pulse must match the next queued event
    initial begin
        logic [11:0] last_out;
        ev_t         e;
        last_out = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_out = keypad_out;
            end else begin
                check("pulse_overlap", 32'(key_press & key_release), 32'd0);
                check("col_onehot", 32'($onehot(col_out)), 32'd1);
                if (key_press || key_release || keypad_out !== last_out) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: actual out=%03h press=%0b release=%0b required no event (prev out=%03h)",
                                 keypad_out, key_press, key_release, last_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (keypad_out !== e.value || key_press !== e.press || key_release !== e.rel) begin
                            n_fail++;
                            $display("FAIL event: actual out=%03h press=%0b release=%0b required out=%03h press=%0b release=%0b",
                                     keypad_out, key_press, key_release, e.value, e.press, e.rel);
                        end
                    end
                    last_out = keypad_out;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_keys(12'h000);
        rst = 1'b0;
        idle(3);
        #1;
        check("reset_col_out", 32'(col_out), 32'h1);
        check("reset_keypad_out", 32'(keypad_out), 32'h0);
        check("reset_key_press", 32'(key_press), 32'h0);
        check("reset_key_release", 32'(key_release), 32'h0);

        // Test 1: column rotation with no keys
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("t1_col_out", 32'(col_out), 32'h1 << ((k / 4) % 3));
        end
        check("t1_keypad_idle", 32'(keypad_out), 32'h0);

        // Test 2: single press and release of row0/col0
        set_keys(12'h001);
        expect_ev(12'h001, 1'b1, 1'b0);
        wait_out("t2_press", 12'h001, LAT_MAX, cyc);
        idle(2 * FRAME);
        set_keys(12'h000);
        expect_ev(12'h000, 1'b0, 1'b1);
        wait_out("t2_release", 12'h000, LAT_MAX, cyc);

        // Test 3: row2/col1 then direct change to row3/col2
        set_keys(12'h080);
        expect_ev(12'h080, 1'b1, 1'b0);
        wait_out("t3_press_080", 12'h080, LAT_MAX, cyc);
        set_keys(12'h800);
        expect_ev(12'h800, 1'b1, 1'b0);
        wait_out("t3_press_800", 12'h800, LAT_MAX, cyc);
        set_keys(12'h000);
        expect_ev(12'h000, 1'b0, 1'b1);
        wait_out("t3_release", 12'h000, LAT_MAX, cyc);

        // Test 4: two keys together are rejected
        set_keys(12'h011);
        idle(8 * FRAME);
        check("t4_multikey_out", 32'(keypad_out), 32'h0);
        set_keys(12'h000);
        idle(4 * FRAME);
        check("t4_after_release", 32'(keypad_out), 32'h0);

        // Test 5: alternating frames never settle, then a steady hold does
        for (int i = 0; i < 10; i++) begin
            set_keys((i % 2 == 0) ? 12'h008 : 12'h000);
            idle(FRAME);
        end
        check("t5_bounce_out", 32'(keypad_out), 32'h0);
        set_keys(12'h008);
        expect_ev(12'h008, 1'b1, 1'b0);
        wait_out("t5_steady", 12'h008, LAT_MAX, cyc);
        set_keys(12'h000);
        expect_ev(12'h000, 1'b0, 1'b1);
        wait_out("t5_release", 12'h000, LAT_MAX, cyc);

        // Test 6: reset mid-drive of column 1 while a key is held
        set_keys(12'h001);
        expect_ev(12'h001, 1'b1, 1'b0);
        wait_out("t6_press", 12'h001, LAT_MAX, cyc);
        cyc = 0;
        while (col_out !== 3'b010 && cyc < 2 * FRAME) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_found_col1", 32'(col_out), 32'h2);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_reset_col_out", 32'(col_out), 32'h1);
        check("t6_reset_keypad_out", 32'(keypad_out), 32'h0);
        check("t6_reset_key_press", 32'(key_press), 32'h0);
        idle(2);
        expect_ev(12'h001, 1'b1, 1'b0);
        rst = 1'b1;
        cyc = 0;
        while (keypad_out !== 12'h001 && cyc < LAT_MAX + 5) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached", 32'(keypad_out), 32'h001);
        check("t6_latency_min", 32'(cyc >= int'(DEB) * FRAME), 32'd1);
        check("t6_latency_max", 32'(cyc <= LAT_MAX), 32'd1);
        #1;
        check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        idle(2 * FRAME);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
